template_rom_streamer: RTL and testbench
========================================

// Module: template_rom_streamer
// PURPOSE
//   Reads a contiguous window of a fruit-template ROM (addr -> rd_data, fixed read latency,
//   no read enable) and emits the bytes as a valid/ready stream with backpressure.
//   Sits between the template ROMs (grape, etc.) and the recognition matcher.
//   Hides ROM latency: sustains 1 beat/cycle while m_ready=1.
// PARAMETERS
//   ADDR_WIDTH  11  ROM address width; window addresses wrap modulo 2**ADDR_WIDTH
//   DATA_WIDTH  8   ROM / stream data width
//   RD_LATENCY  1   cycles from rom_addr to valid rom_rd_data (1 = no output reg, 2 = output reg)
//   localparam FIFO_DEPTH = RD_LATENCY+2
// PORTS
//   clk          in   1             system clock; single clock domain
//   rst          in   1             synchronous, active-high reset
//   start        in   1             pulse: begin a window read (sampled only when busy=0)
//   base_addr    in   ADDR_WIDTH    first ROM address, captured on accepted start
//   length       in   ADDR_WIDTH+1  beat count, 0..2**ADDR_WIDTH, captured on accepted start
//   busy         out  1             high from accepted start until done cycle inclusive
//   done         out  1             1-cycle pulse when the window completes
//   rom_addr     out  ADDR_WIDTH    address to ROM
//   rom_rd_data  in   DATA_WIDTH    ROM read data
//   m_data       out  DATA_WIDTH    stream data
//   m_valid      out  1             stream valid
//   m_ready      in   1             stream ready; beat transfers when m_valid&&m_ready
//   m_last       out  1             high with the final beat of the window
// BEHAVIOUR
//   - Reset: busy=0, done=0, m_valid=0, m_last=0, m_data=0, rom_addr=0; FSM=IDLE; FIFO,
//     in-flight pipe and counters cleared. In-flight ROM reads are discarded (mid-run too).
//   - FSM IDLE -> RUN on start (length!=0); IDLE -> FINISH on start with length==0.
//     RUN -> IDLE on handshake of last beat (done=1 that cycle). FINISH -> IDLE, done=1.
//   - start while busy=1 (including the done cycle) is ignored.
//   - Issue: in RUN, present next address when issued<length and credit>0, where
//     credit = FIFO_DEPTH - in_flight - fifo_count. Address = base_addr+issued, ADDR_WIDTH
//     wrap (2047+1 -> 0). rom_addr holds its last value when not issuing.
//   - In-flight tracking: RD_LATENCY-deep valid shift register; at its output rom_rd_data
//     is written into the FIFO. FIFO can never overflow (credit rule).
//   - Timing: start sampled at edge t -> rom_addr=base at t+1 -> FIFO write at
//     t+1+RD_LATENCY -> m_valid=1 at t+2+RD_LATENCY. Then 1 beat/cycle while m_ready=1.
//   - Stream rules: once m_valid=1, m_valid/m_data/m_last stay stable until handshake.
//     Exactly `length` beats per window, in address order; no duplicates, no drops.
//   - m_last asserted only on beat index length-1; done pulses in that handshake cycle,
//     busy falls the cycle after.
//   - Counters: issued and delivered are ADDR_WIDTH+1 bits (length=2048 legal).
// STRUCTURE
//   - Shared header fruit_rom_defs.vh: ROM_ADDR_WIDTH=11, ROM_DATA_WIDTH=8,
//     ROM_RD_LATENCY defaults; FSM state encodings IDLE/RUN/FINISH.
//   - One sub-module: rom_stream_fifo (sync FIFO, registered output, count port,
//     DEPTH/WIDTH params, sync rst). Issue/credit logic and FSM stay in the top.
// TESTING
//   Bench ROM model: rd_data = addr[7:0]^8'hA5 after RD_LATENCY cycles; scoreboard
//   per beat.
//   1 Full sweep: base=0,length=2048,m_ready=1 -> 2048 beats, beat i = i[7:0]^A5,
//     m_last on beat 2047 only, first m_valid at t+3 (RD_LATENCY=1), no bubbles,
//     done pulse once.
//   2 Wrap: base=2046,length=4 -> data for addrs 2046,2047,0,1; m_last on 4th.
//   3 Backpressure: length=64, m_ready random 50% plus a 20-cycle low hold -> 64
//     correct beats, m_data/m_last stable while m_valid&&!m_ready.
//   4 length=0 -> busy 1 cycle, done at t+1, m_valid never asserted.
//   5 start pulsed while busy (base=100) -> ignored, current window unaffected;
//     rst mid-window -> all outputs 0 next cycle, new start(base=5,length=3) streams
//     5,6,7 cleanly.
//   6 RD_LATENCY=2, length=256, m_ready=1 -> first m_valid at t+4, 256 beats in 256
//     consecutive cycles.

Source files
------------

// File: rtl/template_rom_streamer_pkg.sv
// Shared definitions for the fruit-template ROM streamer.
// Holds the default ROM geometry, the controller state encoding and the
// helper that sizes the output FIFO from the ROM read latency.
package template_rom_streamer_pkg;

  // Default template ROM geometry (grape, etc. ROMs share this layout).
  localparam int ROM_ADDR_WIDTH = 11;
  localparam int ROM_DATA_WIDTH = 8;
  // 1 = ROM without output register, 2 = ROM with output register.
  localparam int ROM_RD_LATENCY = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  // The FIFO must absorb every read that can be in flight plus the head
  // beat. The extra slot lets issue keep going in the cycle a beat leaves.
  function automatic int fifo_depth(input int rd_latency);
    return rd_latency + 2;
  endfunction

endpackage

// File: rtl/rom_stream_fifo.sv
// Synchronous FIFO feeding the streamer output.
// Ports: clk/rst (sync, active-high), wr_en/wr_data push side,
//        rd_en/rd_data/valid pop side (first word visible without a read), count occupancy.
// Storage is a flop array, so rd_data/valid come straight from registers.
module rom_stream_fifo #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             do_wr;
  logic             do_rd;

  // Pointers wrap explicitly because DEPTH is usually not a power of two.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_rd = rd_en && (count != '0);
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_wr = wr_en && ((count != CW'(DEPTH)) || do_rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_wr) begin
        mem[wptr] <= wr_data;
        wptr      <= ptr_next(wptr);
      end
      if (do_rd) begin
        rptr <= ptr_next(rptr);
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rptr];
  assign valid   = (count != '0);

endmodule

// File: rtl/template_rom_streamer.sv
// Streams a contiguous window of a fruit-template ROM as a valid/ready byte stream.
// Ports: clk/rst (sync, active-high); start/base_addr/length window request; busy/done status;
//        rom_addr/rom_rd_data fixed-latency ROM port; m_data/m_valid/m_ready/m_last stream.
// Reads are issued ahead against a credit so ROM latency is hidden (1 beat/cycle at m_ready=1).
module template_rom_streamer
  import template_rom_streamer_pkg::*;
#(
  parameter int ADDR_WIDTH = ROM_ADDR_WIDTH,
  parameter int DATA_WIDTH = ROM_DATA_WIDTH,
  parameter int RD_LATENCY = ROM_RD_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rd_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
);

  localparam int FIFO_DEPTH = fifo_depth(RD_LATENCY);
  localparam int CW         = $clog2(FIFO_DEPTH + 1);
  localparam int SW         = CW + 1;

  state_e              state;
  logic [ADDR_WIDTH:0] len_q;
  logic [ADDR_WIDTH:0] issued;
  logic [ADDR_WIDTH:0] delivered;

  // vpipe[0] marks that rom_addr currently carries a real read; the read
  // data lands in the FIFO when that mark reaches vpipe[RD_LATENCY].
  logic [RD_LATENCY:0] vpipe;

  logic [CW-1:0]       fifo_count;
  logic [SW-1:0]       occupied;
  logic [SW-1:0]       capacity;
  logic                pop;
  logic                launch;
  logic                issue;

  assign pop    = m_valid && m_ready;
  // Only an idle controller takes a request, so start during busy (done cycle included) is dropped.
  assign launch = (state == ST_IDLE) && start && (length != '0);

  // Slots already spoken for: FIFO contents plus every read still travelling.
  // A beat leaving this cycle frees its slot in time for a read issued now,
  // which is what keeps the stream gap-free.
  always_comb begin
    occupied = {{(SW - CW){1'b0}}, fifo_count};
    for (int i = 0; i <= RD_LATENCY; i++) begin
      occupied = occupied + {{(SW - 1){1'b0}}, vpipe[i]};
    end
    capacity = SW'(FIFO_DEPTH) + {{(SW - 1){1'b0}}, pop};
  end

  assign issue = (state == ST_RUN) && (issued < len_q) && (occupied < capacity);

  // The head beat index is the number already delivered.
  assign m_last = m_valid && (delivered == (len_q - 1'b1));

  // done has to coincide with the final handshake, so it is decoded from the
  // state and the live handshake rather than registered.
  assign done = ((state == ST_RUN) && pop && m_last) || (state == ST_FINISH);
  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      len_q     <= '0;
      issued    <= '0;
      delivered <= '0;
      rom_addr  <= '0;
      vpipe     <= '0;
    end else begin
      vpipe <= {vpipe[RD_LATENCY-1:0], (issue || launch)};

      if (pop) begin
        delivered <= delivered + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            len_q     <= length;
            delivered <= '0;
            if (length == '0) begin
              issued <= '0;
              state  <= ST_FINISH;
            end else begin
              // First read goes out with the accepted start; the FIFO is
              // empty here so no credit check is needed.
              rom_addr <= base_addr;
              issued   <= {{ADDR_WIDTH{1'b0}}, 1'b1};
              state    <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (issue) begin
            // Natural ADDR_WIDTH overflow gives the modulo wrap of the window.
            rom_addr <= rom_addr + 1'b1;
            issued   <= issued + 1'b1;
          end
          if (done) begin
            state <= ST_IDLE;
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  rom_stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (vpipe[RD_LATENCY]),
    .wr_data (rom_rd_data),
    .rd_en   (m_ready),
    .rd_data (m_data),
    .valid   (m_valid),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_template_rom_streamer.sv
// Bench for template_rom_streamer: one instance with RD_LATENCY=1, one with RD_LATENCY=2.
// ROM model returns addr[7:0]^A5 after the read latency; a per-beat scoreboard
// compares against the window the bench expects from (base + i) mod 2048.
module tb_template_rom_streamer;

  localparam int AW = 11;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start_a;
  logic          start_b;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          m_ready;

  logic          busy_a, done_a, m_valid_a, m_last_a;
  logic [AW-1:0] rom_addr_a;
  logic [DW-1:0] rd_a, m_data_a;
  logic          busy_b, done_b, m_valid_b, m_last_b;
  logic [AW-1:0] rom_addr_b;
  logic [DW-1:0] rd_b, m_data_b;

  template_rom_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .base_addr(base_addr), .length(length),
    .busy(busy_a), .done(done_a), .rom_addr(rom_addr_a), .rom_rd_data(rd_a),
    .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready), .m_last(m_last_a)
  );

  template_rom_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .base_addr(base_addr), .length(length),
    .busy(busy_b), .done(done_b), .rom_addr(rom_addr_b), .rom_rd_data(rd_b),
    .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready), .m_last(m_last_b)
  );

  // ROM models
  logic [DW-1:0] rom_b_s1;
  always @(posedge clk) begin
    rd_a     <= rom_addr_a[7:0] ^ 8'hA5;
    rom_b_s1 <= rom_addr_b[7:0] ^ 8'hA5;
    rd_b     <= rom_b_s1;
  end

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard / monitor state
  logic [DW:0] exp_q[$];
  bit          sel = 1'b0;
  int          cyc_n = 0;
  int          t_start = 0;
  int          beats, done_cnt, busy_cnt, first_valid_rel, last_rel, done_rel;
  bit          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic        prev_last;
  bit          rdy_mode = 1'b0;
  int          hold_at = -1;
  int          hold_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: observe at negedge, then advance past the next posedge.
  task automatic cyc();
    logic v, l, b, d;
    logic [DW-1:0] dat;
    logic [DW:0] e;
    int rel;
    @(negedge clk);
    v   = sel ? m_valid_b : m_valid_a;
    l   = sel ? m_last_b  : m_last_a;
    b   = sel ? busy_b    : busy_a;
    d   = sel ? done_b    : done_a;
    dat = sel ? m_data_b  : m_data_a;
    rel = cyc_n - t_start + 1;
    if (prev_stall) begin
      chk("hold_valid", 32'(v), 32'd1);
      chk("hold_data", 32'(dat), 32'(prev_data));
      chk("hold_last", 32'(l), 32'(prev_last));
    end
    if (v && m_ready) begin
      if (exp_q.size() == 0) begin
        chk("beat_without_expectation", 32'(v), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", 32'(dat), 32'(e[DW-1:0]));
        chk("beat_last", 32'(l), 32'(e[DW]));
      end
      beats++;
      last_rel = rel;
    end
    if (v && first_valid_rel < 0) first_valid_rel = rel;
    if (b) busy_cnt++;
    if (d) begin
      done_cnt++;
      if (done_rel < 0) done_rel = rel;
    end
    prev_stall = v && !m_ready;
    prev_data  = dat;
    prev_last  = l;
    @(posedge clk);
    cyc_n++;
    #1;
    if (hold_cnt > 0) begin
      m_ready = 1'b0;
      hold_cnt--;
    end else if (cyc_n == hold_at) begin
      m_ready  = 1'b0;
      hold_cnt = 19;
    end else if (rdy_mode) begin
      m_ready = 1'($urandom_range(0, 1));
    end else begin
      m_ready = 1'b1;
    end
  endtask

  task automatic begin_window(input bit use_b, input int base, input int len);
    int a;
    logic [DW-1:0] byt;
    sel = use_b;
    for (int i = 0; i < len; i++) begin
      a   = (base + i) % 2048;
      byt = 8'(a) ^ 8'hA5;
      exp_q.push_back({(i == len - 1), byt});
    end
    beats = 0; done_cnt = 0; busy_cnt = 0;
    first_valid_rel = -1; last_rel = -1; done_rel = -1;
    base_addr = AW'(base);
    length    = (AW + 1)'(len);
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    cyc();
    t_start = cyc_n;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_window(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || (sel ? busy_b : busy_a)) && n < budget) begin
      cyc();
      n++;
    end
    chk("window_in_budget", 32'(n < budget), 32'd1);
  endtask

  task automatic check_window(input int len, input int lat, input bit gapless);
    chk("beat_count", 32'(beats), 32'(len));
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    if (len > 0) begin
      chk("first_valid_cycle", 32'(first_valid_rel), 32'(2 + lat));
      chk("done_on_last_beat", 32'(done_rel), 32'(last_rel));
      chk("busy_until_done", 32'(busy_cnt), 32'(last_rel));
      if (gapless) chk("no_bubbles", 32'(last_rel - first_valid_rel), 32'(len - 1));
    end else begin
      chk("len0_valid_seen", 32'(first_valid_rel), 32'hFFFF_FFFF);
      chk("len0_done_cycle", 32'(done_rel), 32'd1);
      chk("len0_busy_cycles", 32'(busy_cnt), 32'd1);
    end
  endtask

  task automatic check_outputs_zero(input string tag, input bit use_b);
    chk({tag, "_busy"},     32'(use_b ? busy_b : busy_a), 32'd0);
    chk({tag, "_done"},     32'(use_b ? done_b : done_a), 32'd0);
    chk({tag, "_m_valid"},  32'(use_b ? m_valid_b : m_valid_a), 32'd0);
    chk({tag, "_m_last"},   32'(use_b ? m_last_b : m_last_a), 32'd0);
    chk({tag, "_m_data"},   32'(use_b ? m_data_b : m_data_a), 32'd0);
    chk({tag, "_rom_addr"}, 32'(use_b ? rom_addr_b : rom_addr_a), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    base_addr = '0; length = '0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset_a", 1'b0);
    check_outputs_zero("reset_b", 1'b1);
    rst = 1'b0;
    cyc();

    // 1: full sweep
    rdy_mode = 1'b0;
    begin_window(1'b0, 0, 2048);
    wait_window(2048 + 100);
    check_window(2048, 1, 1'b1);
    repeat (3) cyc();
    chk("sweep_no_extra_done", 32'(done_cnt), 32'd1);

    // 2: address wrap
    begin_window(1'b0, 2046, 4);
    wait_window(100);
    check_window(4, 1, 1'b1);

    // 3: backpressure, random ready plus a 20-cycle hold
    rdy_mode = 1'b1;
    begin_window(1'b0, 700, 64);
    hold_at = t_start + 30;
    wait_window(64 * 6 + 100);
    check_window(64, 1, 1'b0);
    rdy_mode = 1'b0;
    hold_at  = -1;
    cyc();

    // 4: zero-length window
    begin_window(1'b0, 123, 0);
    repeat (4) cyc();
    check_window(0, 1, 1'b0);

    // 5a: start pulses while busy are ignored
    begin_window(1'b0, 10, 40);
    repeat (5) cyc();
    start_a = 1'b1; base_addr = 11'd100; length = 12'd7;
    repeat (3) cyc();
    start_a = 1'b0;
    wait_window(300);
    check_window(40, 1, 1'b1);
    repeat (3) cyc();
    chk("busy_start_not_taken", 32'(done_cnt), 32'd1);

    // 5b: reset mid-window, then a clean short window
    begin_window(1'b0, 300, 50);
    repeat (10) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_outputs_zero("midrst", 1'b0);
    exp_q.delete();
    prev_stall = 1'b0;
    begin_window(1'b0, 5, 3);
    wait_window(100);
    check_window(3, 1, 1'b1);

    // 6: RD_LATENCY=2 instance
    begin_window(1'b1, 1000, 256);
    wait_window(256 + 100);
    check_window(256, 2, 1'b1);
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
